rv_fetch_bus: RTL and testbench

Instruction-fetch bus master that feeds the fetch buffer (`rv_fetch_buf`). It issues word-aligned 32-bit reads on the instruction bus and splits each returned word into two halfwords. It pushes one or two halfwords per word into the buffer, throttled by the buffer's not-full flag. On a branch or redirect it flushes the buffer, reloads its start PC and discards any response still in flight.

---
 rtl/rv_fetch_bus_if.sv | 15 +
 rtl/rv_fetch_bus.sv | 96 +++++++++
 tb/tb_rv_fetch_bus.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_bus_if.sv
// rv_fetch_bus_if: instruction-bus read channel between the fetch master and memory.
//   req    master -> slave  read request, held until ack
//   addr   master -> slave  word address, stable while req is high and not acked
//   ack    slave -> master  read complete, rdata valid in the same cycle
//   rdata  slave -> master  32-bit read data
interface rv_fetch_bus_if #(
    parameter int IADDR_SPACE_BITS = 16
);
    logic                        req;
    logic [IADDR_SPACE_BITS-1:2] addr;
    logic                        ack;
    logic [31:0]                 rdata;
    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv_fetch_bus.sv
// rv_fetch_bus: instruction-fetch bus master that splits 32-bit words into halfword pushes for the fetch buffer.
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_redirect, i_redirect_pc restart fetch at a new halfword-aligned PC
//   ibus                     instruction read channel (master side)
//   o_flush_n, o_pc          buffer reset pulse and the start PC it loads
//   o_data_lo, o_data_hi     halfwords to the buffer
//   o_push_single/_double    one or two halfword push strobes
//   i_buf_not_full           buffer has at least 4 halfwords free
module rv_fetch_bus #(
    parameter int                          IADDR_SPACE_BITS = 16,
    parameter logic [IADDR_SPACE_BITS-1:0] RESET_PC         = '0
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_redirect,
    input  logic [IADDR_SPACE_BITS-1:1] i_redirect_pc,
    rv_fetch_bus_if.master              ibus,
    output logic                        o_flush_n,
    output logic [IADDR_SPACE_BITS-1:1] o_pc,
    output logic [15:0]                 o_data_lo,
    output logic [15:0]                 o_data_hi,
    output logic                        o_push_single,
    output logic                        o_push_double,
    input  logic                        i_buf_not_full
);
    localparam int AW = IADDR_SPACE_BITS - 2;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               faddr_q, faddr_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic                        half_q, half_d;
    logic [IADDR_SPACE_BITS-1:1] pc_q, pc_d;
    logic [15:0]                 lo_q, lo_d, hi_q, hi_d;
    logic                        single_q, single_d, double_q, double_d;
    logic                        req_q, flush_n_q;
    logic                        go, accept;

    always_comb begin
        // a pending push is not yet visible in the buffer's not-full flag, so hold off issuing
        go       = i_buf_not_full & ~(single_q | double_q);
        accept   = (state_q == REQ) & ibus.ack & ~i_redirect;
        faddr_d  = i_redirect ? i_redirect_pc[IADDR_SPACE_BITS-1:2] : accept ? faddr_q + AW'(1) : faddr_q;
        half_d   = i_redirect ? i_redirect_pc[1] : half_q & ~accept;
        pc_d     = i_redirect ? i_redirect_pc : pc_q;
        lo_d     = (accept & ~half_q) ? ibus.rdata[15:0] : lo_q;
        hi_d     = accept ? ibus.rdata[31:16] : hi_q;
        single_d = accept & half_q;
        double_d = accept & ~half_q;
        unique case (state_q)
            IDLE:    state_d = (i_redirect | go) ? REQ : IDLE;
            REQ:     state_d = ibus.ack ? ((i_redirect | go) ? REQ : IDLE) : (i_redirect ? DROP : REQ);
            default: state_d = ibus.ack ? REQ : DROP;
        endcase
        // while draining a stale request the bus must keep seeing the old address
        addr_d   = (state_d == DROP) ? addr_q : faddr_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            faddr_q   <= RESET_PC[IADDR_SPACE_BITS-1:2];
            addr_q    <= RESET_PC[IADDR_SPACE_BITS-1:2];
            half_q    <= RESET_PC[1];
            pc_q      <= RESET_PC[IADDR_SPACE_BITS-1:1];
            lo_q      <= '0;
            hi_q      <= '0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            req_q     <= 1'b0;
            flush_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            faddr_q   <= faddr_d;
            addr_q    <= addr_d;
            half_q    <= half_d;
            pc_q      <= pc_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            single_q  <= single_d;
            double_q  <= double_d;
            req_q     <= state_d != IDLE;
            flush_n_q <= ~i_redirect;
        end
    end

    assign ibus.req      = req_q;
    assign ibus.addr     = addr_q;
    assign o_flush_n     = flush_n_q;
    assign o_pc          = pc_q;
    assign o_data_lo     = lo_q;
    assign o_data_hi     = hi_q;
    assign o_push_single = single_q;
    assign o_push_double = double_q;
endmodule

// File: tb/tb_rv_fetch_bus.sv
// tb_rv_fetch_bus: vector table, corner sequences and a random soak against a halfword-stream buffer model.
module tb_rv_fetch_bus;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        redir;
    logic [15:1] rpc;
    logic        fl;
    logic [15:1] pc;
    logic [15:0] lo, hi;
    logic        ps, pd, nf;
    int          errors = 0;
    int          checks = 0;

    rv_fetch_bus_if #(.IADDR_SPACE_BITS(16)) bus ();

    rv_fetch_bus #(.IADDR_SPACE_BITS(16), .RESET_PC(16'h0000)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_redirect     (redir),
        .i_redirect_pc  (rpc),
        .ibus           (bus),
        .o_flush_n      (fl),
        .o_pc           (pc),
        .o_data_lo      (lo),
        .o_data_hi      (hi),
        .o_push_single  (ps),
        .o_push_double  (pd),
        .i_buf_not_full (nf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [15:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        nf;
        logic        req;
        logic [13:0] addr;
        logic        ps;
        logic        pd;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        fl;
        logic [15:0] pc;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [15:0] p, input logic a, input logic [31:0] d, input logic n,
                       input logic q, input logic [13:0] ad, input logic s, input logic dd,
                       input logic [15:0] l, input logic [15:0] h, input logic f, input logic [15:0] c);
        vec_t v;
        v.redir = r; v.rpc = p; v.ack = a; v.rdata = d; v.nf = n;
        v.req = q; v.addr = ad; v.ps = s; v.pd = dd; v.lo = l; v.hi = h; v.fl = f; v.pc = c;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [15:0] p, input logic a, input logic [31:0] d, input logic n);
        redir = r;
        rpc = p[15:1];
        bus.ack = a;
        bus.rdata = d;
        nf = n;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_vec(input string t, input vec_t v);
        chk({t, ".req"}, bus.req, v.req);
        chk({t, ".addr"}, bus.addr, v.addr);
        chk({t, ".single"}, ps, v.ps);
        chk({t, ".double"}, pd, v.pd);
        chk({t, ".lo"}, lo, v.lo);
        chk({t, ".hi"}, hi, v.hi);
        chk({t, ".flush_n"}, fl, v.fl);
        chk({t, ".pc"}, {pc, 1'b0}, v.pc);
    endtask

    function automatic logic [31:0] word(input logic [13:0] a);
        return {2'b10, a, ~a, 2'b01};
    endfunction

    function automatic logic [15:0] hw(input logic [15:0] p);
        logic [31:0] w;
        w = word(p[15:2]);
        return p[1] ? w[31:16] : w[15:0];
    endfunction

    logic [15:0] exp_pc, pp, p;
    logic [13:0] pad;
    logic        pr, prq, pak, a, r, nfv;
    int          occ;

    initial begin
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h000, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000);
        add(0, 16'h0000, 1, 32'h00130013, 1,  1, 14'h001, 0, 1, 16'h0013, 16'h0013, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h001, 0, 0, 16'h0013, 16'h0013, 1, 16'h0000);
        add(0, 16'h0000, 1, 32'h22221111, 1,  1, 14'h002, 0, 1, 16'h1111, 16'h2222, 1, 16'h0000);
        add(0, 16'h0000, 1, 32'h44443333, 1,  0, 14'h003, 0, 1, 16'h3333, 16'h4444, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 1,  0, 14'h003, 0, 0, 16'h3333, 16'h4444, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h003, 0, 0, 16'h3333, 16'h4444, 1, 16'h0000);
        add(0, 16'h0000, 1, 32'h66665555, 0,  0, 14'h004, 0, 1, 16'h5555, 16'h6666, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 0,  0, 14'h004, 0, 0, 16'h5555, 16'h6666, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 0,  0, 14'h004, 0, 0, 16'h5555, 16'h6666, 1, 16'h0000);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h004, 0, 0, 16'h5555, 16'h6666, 1, 16'h0000);
        add(1, 16'h0102, 0, 32'h0, 1,  1, 14'h004, 0, 0, 16'h5555, 16'h6666, 0, 16'h0102);
        add(0, 16'h0000, 1, 32'hDEADBEEF, 1,  1, 14'h040, 0, 0, 16'h5555, 16'h6666, 1, 16'h0102);
        add(0, 16'h0000, 1, 32'hABCD1234, 1,  1, 14'h041, 1, 0, 16'h5555, 16'hABCD, 1, 16'h0102);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h041, 0, 0, 16'h5555, 16'hABCD, 1, 16'h0102);
        add(0, 16'h0000, 1, 32'h87654321, 1,  1, 14'h042, 0, 1, 16'h4321, 16'h8765, 1, 16'h0102);
        add(1, 16'h0200, 1, 32'h99998888, 1,  1, 14'h080, 0, 0, 16'h4321, 16'h8765, 0, 16'h0200);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h080, 0, 0, 16'h4321, 16'h8765, 1, 16'h0200);
        add(1, 16'h0040, 1, 32'h77777777, 1,  1, 14'h010, 0, 0, 16'h4321, 16'h8765, 0, 16'h0040);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h010, 0, 0, 16'h4321, 16'h8765, 1, 16'h0040);
        add(1, 16'h0200, 0, 32'h0, 1,  1, 14'h010, 0, 0, 16'h4321, 16'h8765, 0, 16'h0200);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h010, 0, 0, 16'h4321, 16'h8765, 1, 16'h0200);
        add(0, 16'h0000, 0, 32'h0, 1,  1, 14'h010, 0, 0, 16'h4321, 16'h8765, 1, 16'h0200);
        add(0, 16'h0000, 1, 32'h12345678, 1,  1, 14'h080, 0, 0, 16'h4321, 16'h8765, 1, 16'h0200);
        add(0, 16'h0000, 1, 32'h0BADF00D, 1,  1, 14'h081, 0, 1, 16'hF00D, 16'h0BAD, 1, 16'h0200);

        rst_n = 1'b0;
        redir = 1'b0;
        rpc = '0;
        bus.ack = 1'b0;
        bus.rdata = '0;
        nf = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.req", bus.req, 0);
        chk("reset.addr", bus.addr, 0);
        chk("reset.flush_n", fl, 0);
        chk("reset.push", {ps, pd}, 0);
        chk("reset.data", {hi, lo}, 0);
        chk("reset.pc", {pc, 1'b0}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].redir, tv[i].rpc, tv[i].ack, tv[i].rdata, tv[i].nf);
            check_vec($sformatf("vec%0d", i), tv[i]);
        end

        drive(1, 16'h0300, 0, 32'h0, 1);
        chk("drop1.req", bus.req, 1);
        chk("drop1.addr", bus.addr, 14'h081);
        chk("drop1.flush_n", fl, 0);
        chk("drop1.pc", {pc, 1'b0}, 16'h0300);
        drive(1, 16'h0106, 0, 32'h0, 1);
        chk("drop2.addr", bus.addr, 14'h081);
        chk("drop2.flush_n", fl, 0);
        chk("drop2.pc", {pc, 1'b0}, 16'h0106);
        drive(0, 16'h0000, 0, 32'h0, 1);
        chk("drop3.req", bus.req, 1);
        chk("drop3.flush_n", fl, 1);
        drive(0, 16'h0000, 1, 32'h55555555, 1);
        chk("drop4.addr", bus.addr, 14'h041);
        chk("drop4.push", {ps, pd}, 0);
        drive(0, 16'h0000, 1, 32'hCAFE0000, 1);
        chk("drop5.push", {ps, pd}, 2'b10);
        chk("drop5.hi", hi, 16'hCAFE);
        chk("drop5.lo", lo, 16'hF00D);
        chk("drop5.addr", bus.addr, 14'h042);

        drive(1, 16'hFFFC, 1, 32'h0, 1);
        chk("wrap1.addr", bus.addr, 14'h3FFF);
        chk("wrap1.push", {ps, pd}, 0);
        drive(0, 16'h0000, 1, 32'h11112222, 1);
        chk("wrap2.push", {ps, pd}, 2'b01);
        chk("wrap2.data", {hi, lo}, 32'h11112222);
        chk("wrap2.addr", bus.addr, 14'h0000);
        drive(0, 16'h0000, 0, 32'h0, 1);
        chk("wrap3.req", bus.req, 1);

        rst_n = 1'b0;
        #1;
        chk("midreset.req", bus.req, 0);
        chk("midreset.flush_n", fl, 0);
        chk("midreset.outs", {ps, pd, hi, lo}, 0);
        chk("midreset.pc", {pc, 1'b0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(0, 16'h0000, 0, 32'h0, 1);
        chk("rerun.req", bus.req, 1);
        chk("rerun.flush_n", fl, 1);

        exp_pc = 16'h0000;
        occ = 0;
        pr = 1'b0;
        pp = '0;
        prq = 1'b0;
        pak = 1'b0;
        pad = '0;
        for (int c = 0; c < 3000; c++) begin
            if (pr) begin
                chk("soak.flush_n", fl, 0);
                chk("soak.pc", {pc, 1'b0}, pp);
                exp_pc = pp;
            end else begin
                chk("soak.flush_n", fl, 1);
            end
            if (prq && !pak) chk("soak.addr_hold", {bus.req, bus.addr}, {1'b1, pad});
            if (!fl) begin
                occ = 0;
                nfv = 1'b1;
                chk("soak.push_in_flush", {ps, pd}, 0);
            end else begin
                nfv = (8 - occ) >= 4;
                if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
                if (ps || pd) chk("soak.push_excl", ps & pd, 0);
                if (ps) begin
                    chk("soak.single_odd", exp_pc[1], 1);
                    chk("soak.single_hi", hi, hw(exp_pc));
                    exp_pc = exp_pc + 16'd2;
                    occ += 1;
                end else if (pd) begin
                    chk("soak.double_even", exp_pc[1], 0);
                    chk("soak.double_lo", lo, hw(exp_pc));
                    chk("soak.double_hi", hi, hw(exp_pc + 16'd2));
                    exp_pc = exp_pc + 16'd4;
                    occ += 2;
                end
                chk("soak.overflow", occ > 8, 0);
            end
            a = bus.req && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 24) == 0);
            p = 16'($urandom) & 16'hFFFE;
            prq = bus.req;
            pak = a;
            pad = bus.addr;
            pr = r;
            pp = p;
            drive(r, p, a, a ? word(bus.addr) : 32'($urandom), nfv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
